// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// Executes MULT, MULTU, DIV and DIVU on forwarded rs/rt operands into private
// HI/LO registers. mthi/mtlo writes are accepted only while idle.
// busy stalls mfhi/mflo and further mul/div issue in the hazard unit.
//
// Build option: define MULDIV_FAST_MULT_EN to complete MULT/MULTU in a single
// cycle with a combinational product. Divides always use the iterative path.
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; mthi/mtlo writes accepted
//   ST_RUN  | one shift-add (mul) or restoring shift-subtract (div) step
//   ST_FIN  | apply result signs, write hi/lo, pulse done

module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 is_div_q,   is_div_d;
    logic                 neg_main_q, neg_main_d;   // negate product / quotient
    logic                 neg_rem_q,  neg_rem_d;    // negate remainder
    logic                 done_q,     done_d;
    logic [WIDTH-1:0]     mcand_q,    mcand_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     hi_q,       hi_d;
    logic [WIDTH-1:0]     lo_q,       lo_d;
    // Mul: {partial product, remaining multiplier bits}.
    // Div: {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0]   acc_q,      acc_d;

    logic                 op_div;
    logic                 a_neg;
    logic                 b_neg;
    logic                 b_zero;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    // Operand magnitudes, single iteration step and final sign correction.
    always_comb begin
        op_div = op[1];
        a_neg  = ~op[0] & src_a[WIDTH-1];
        b_neg  = ~op[0] & src_b[WIDTH-1];
        b_zero = (src_b == {WIDTH{1'b0}});
        // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;

        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Trial remainder is the old remainder shifted left with the next dividend bit.
        // It can reach WIDTH+1 bits for large unsigned divisors.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, mcand_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod_signed = neg_main_q ? -acc_q : acc_q;
        if (is_div_q) begin
            res_hi = neg_rem_q  ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            res_lo = neg_main_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end else begin
            res_hi = prod_signed[2*WIDTH-1:WIDTH];
            res_lo = prod_signed[WIDTH-1:0];
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority; a same-cycle mthi/mtlo is dropped
                    is_div_d   = op_div;
                    neg_main_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    if (op_div) begin
                        if (b_zero) begin
                            // Preload the divide-by-zero result so FIN passes it through unchanged.
                            acc_d      = {src_a, {WIDTH{1'b1}}};
                            neg_main_d = 1'b0;
                            neg_rem_d  = 1'b0;
                            cnt_d      = {CNT_W{1'b0}};
                            state_d    = ST_FIN;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            mcand_d = b_mag;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = ST_RUN;
                        end
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        acc_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_FIN;
`else
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        mcand_d = a_mag;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = ST_RUN;
`endif
                    end
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            ST_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
            mcand_q    <= {WIDTH{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            acc_q      <= {(2*WIDTH){1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
            mcand_q    <= mcand_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit in the EX stage, alongside the main ALU. Consumes the forwarded operands produced by the first and second ALU source muxes (rs path after FwdA, rt path after FwdB) and executes MULT, MULTU, DIV and DIVU into private HI/LO registers. Raises busy so the hazard unit can stall mfhi/mflo and further mul/div issue.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
clk  input  1  pipeline clock
rst  input  1  reset, synchronous, active-high
start  input  1  issue a mul/div op this cycle (from ID/EX control)
op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
src_a  input  WIDTH  rs operand from first ALU source mux
src_b  input  WIDTH  rt operand from second ALU source mux
wr_hi  input  1  mthi write strobe
wr_lo  input  1  mtlo write strobe
wdata  input  WIDTH  mthi/mtlo data (rs operand)
busy  output  1  operation in progress; stall request to hazard unit
done  output  1  one-cycle pulse; hi/lo just updated by a mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset mid-operation: abort at the next edge and drop the partial result; hi/lo are forced to 0.
- FSM states:
  - IDLE: start=1 latches op, operand magnitudes and result signs, then goes to RUN with counter=WIDTH. DIV/DIVU with src_b==0 goes to FIN instead.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle. Counter decrements; when it reaches 1, go to FIN.
  - FIN: write hi/lo, pulse done=1, return to IDLE.
- busy=1 exactly while state is RUN or FIN.
- Latency: start sampled at edge T; hi/lo valid and done=1 after edge T+WIDTH+1 (33 cycles for WIDTH=32). Divide by zero: done after edge T+1.
- Signed ops (MULT, DIV): compute on magnitudes, then negate.
  - Product: negate if sign(a) XOR sign(b).
  - Quotient: negate if sign(a) XOR sign(b).
  - Remainder: takes the sign of the dividend.
  - 0x80000000 magnitude is handled as unsigned 2^31.
- Multiply: {hi,lo} = full 2*WIDTH product.
- Divide: lo = quotient, hi = remainder.
- Divide by zero: hi = src_a, lo = all ones. No exception.
- Overflow DIV 0x80000000 / -1: lo=0x80000000, hi=0.
- start while busy: ignored; no effect on the running op.
- mthi/mtlo:
  - In IDLE, wr_hi/wr_lo update hi/lo from wdata at the next edge.
  - Ignored while busy.
  - start and wr_* in the same IDLE cycle: start wins and the write is dropped.
  - wr_hi and wr_lo together: both write wdata.
- hi/lo hold their value between operations; not modified during RUN.

Optional Feature:
MULDIV_FAST_MULT_EN
- Defined: MULT/MULTU complete in one cycle using a single-cycle product. IDLE goes to FIN directly; done after edge T+1; busy high for one cycle (FIN). Divides are unchanged.
- Undefined: all ops use the iterative path with the latencies above.

Test Plan:
1. MULT, src_a=0xFFFFFFFE, src_b=0x00000003 -> busy for 33 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU, src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MULDIV_FAST_MULT_EN -> same result, done at cycle 1.
3. DIV -7/2 (0xFFFFFFF9, 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 -> done after 1 cycle, hi=0x00000007, lo=0xFFFFFFFF.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000. Second start pulse at cycle 5 (while busy) -> ignored, result unchanged.
5. MULT running, rst=1 at cycle 10 -> next edge: busy=0, done=0, hi=lo=0. A following MULTU 5*6 completes with lo=30, hi=0.
6. IDLE with wr_hi=1, wdata=0x12345678 -> hi=0x12345678, lo unchanged. Same-cycle start(MULTU 2*2) + wr_lo -> lo=4, mtlo dropped.
